// File: rtl/axi_ram_pkg.sv
// Shared constants for the AXI RAM responder.
// Holds response/burst codes, FSM state encodings and the byte-offset helper.
package axi_ram_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_FETCH = 2'd1;
    localparam logic [1:0] R_DATA  = 2'd2;

    // Bit position of the word index inside a byte address.
    function automatic int unsigned addr_lsb(input int unsigned mask_width);
        return $clog2(mask_width);
    endfunction

endpackage

// File: rtl/axi_ram_mem.sv
// Simple dual-port RAM: one byte-enabled write port, one registered read port.
// Only the read register is reset; array contents survive reset.
module axi_ram_mem #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data
);

    localparam int unsigned BYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned i = 0; i < BYTES; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
                end
            end
        end
    end

    // Array read sees pre-write contents, giving read-before-write on collisions.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[rd_addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/axi_ram_responder.sv
// AXI4 slave backed by an internal RAM, standing in for the MIG DDR AXI port.
// Independent write and read FSMs, one outstanding transaction per direction.
module axi_ram_responder
    import axi_ram_pkg::*;
#(
    parameter int APP_ADDR_WIDTH = 28,
    parameter int APP_DATA_WIDTH = 128,
    parameter int APP_MASK_WIDTH = 16,
    parameter int MEM_WORDS_LOG2 = 12,
    parameter int CALIB_CYCLES   = 16
) (
    input  logic                      ui_clk,
    input  logic                      ui_rst,
    output logic                      init_calib_complete,
    input  logic [3:0]                s_axi_awid,
    input  logic [APP_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]                s_axi_awlen,
    input  logic [2:0]                s_axi_awsize,
    input  logic [1:0]                s_axi_awburst,
    input  logic                      s_axi_awlock,
    input  logic [3:0]                s_axi_awcache,
    input  logic [2:0]                s_axi_awprot,
    input  logic [3:0]                s_axi_awqos,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,
    input  logic [APP_DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [APP_MASK_WIDTH-1:0] s_axi_wstrb,
    input  logic                      s_axi_wlast,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,
    output logic [3:0]                s_axi_bid,
    output logic [1:0]                s_axi_bresp,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,
    input  logic [3:0]                s_axi_arid,
    input  logic [APP_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]                s_axi_arlen,
    input  logic [2:0]                s_axi_arsize,
    input  logic [1:0]                s_axi_arburst,
    input  logic                      s_axi_arlock,
    input  logic [3:0]                s_axi_arcache,
    input  logic [2:0]                s_axi_arprot,
    input  logic [3:0]                s_axi_arqos,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    output logic [3:0]                s_axi_rid,
    output logic [APP_DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rlast,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready
);

    localparam int unsigned ADDR_LSB = addr_lsb(APP_MASK_WIDTH);
    localparam int unsigned CNT_W    = $clog2(CALIB_CYCLES + 1);

    logic [CNT_W-1:0] calib_cnt_q, calib_cnt_d;
    logic             calib_done_q, calib_done_d;

    logic [1:0]                wstate_q, wstate_d;
    logic [3:0]                wid_q, wid_d;
    logic [MEM_WORDS_LOG2-1:0] waddr_q, waddr_d;
    logic [7:0]                wlen_q, wlen_d;
    logic [1:0]                wburst_q, wburst_d;
    logic [7:0]                wbeat_q, wbeat_d;
    logic                      werr_q, werr_d;
    logic [1:0]                bresp_q, bresp_d;

    logic [1:0]                rstate_q, rstate_d;
    logic [3:0]                rid_q, rid_d;
    logic [MEM_WORDS_LOG2-1:0] raddr_q, raddr_d;
    logic [7:0]                rlen_q, rlen_d;
    logic [1:0]                rburst_q, rburst_d;
    logic [7:0]                rbeat_q, rbeat_d;

    logic mem_we;
    logic mem_re;

    always_comb begin
        calib_cnt_d  = calib_cnt_q;
        calib_done_d = calib_done_q;
        if (!calib_done_q) begin
            calib_cnt_d = calib_cnt_q + 1'b1;
            if (calib_cnt_q == CNT_W'(CALIB_CYCLES - 1)) begin
                calib_done_d = 1'b1;
            end
        end
    end

    // Error flag accumulates misplaced wlast on non-final beats; final beat adds missing wlast.
    always_comb begin
        wstate_d = wstate_q;
        wid_d    = wid_q;
        waddr_d  = waddr_q;
        wlen_d   = wlen_q;
        wburst_d = wburst_q;
        wbeat_d  = wbeat_q;
        werr_d   = werr_q;
        bresp_d  = bresp_q;
        mem_we   = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                if (s_axi_awvalid && calib_done_q) begin
                    wid_d    = s_axi_awid;
                    waddr_d  = s_axi_awaddr[ADDR_LSB +: MEM_WORDS_LOG2];
                    wlen_d   = s_axi_awlen;
                    wburst_d = s_axi_awburst;
                    wbeat_d  = '0;
                    werr_d   = 1'b0;
                    wstate_d = W_DATA;
                end
            end
            W_DATA: begin
                if (s_axi_wvalid) begin
                    mem_we = 1'b1;
                    if (wbeat_q == wlen_q) begin
                        bresp_d  = (werr_q || !s_axi_wlast) ? RESP_SLVERR : RESP_OKAY;
                        wstate_d = W_RESP;
                    end else begin
                        werr_d  = werr_q | s_axi_wlast;
                        wbeat_d = wbeat_q + 1'b1;
                        if (wburst_q != BURST_FIXED) begin
                            waddr_d = waddr_q + 1'b1;
                        end
                    end
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    wstate_d = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    always_comb begin
        rstate_d = rstate_q;
        rid_d    = rid_q;
        raddr_d  = raddr_q;
        rlen_d   = rlen_q;
        rburst_d = rburst_q;
        rbeat_d  = rbeat_q;
        mem_re   = 1'b0;
        case (rstate_q)
            R_IDLE: begin
                if (s_axi_arvalid && calib_done_q) begin
                    rid_d    = s_axi_arid;
                    raddr_d  = s_axi_araddr[ADDR_LSB +: MEM_WORDS_LOG2];
                    rlen_d   = s_axi_arlen;
                    rburst_d = s_axi_arburst;
                    rbeat_d  = '0;
                    rstate_d = R_FETCH;
                end
            end
            R_FETCH: begin
                mem_re   = 1'b1;
                rstate_d = R_DATA;
            end
            R_DATA: begin
                if (s_axi_rready) begin
                    if (rbeat_q == rlen_q) begin
                        rstate_d = R_IDLE;
                    end else begin
                        rbeat_d  = rbeat_q + 1'b1;
                        rstate_d = R_FETCH;
                        if (rburst_q != BURST_FIXED) begin
                            raddr_d = raddr_q + 1'b1;
                        end
                    end
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge ui_clk or posedge ui_rst) begin
        if (ui_rst) begin
            calib_cnt_q  <= '0;
            calib_done_q <= 1'b0;
            wstate_q     <= W_IDLE;
            wid_q        <= '0;
            waddr_q      <= '0;
            wlen_q       <= '0;
            wburst_q     <= '0;
            wbeat_q      <= '0;
            werr_q       <= 1'b0;
            bresp_q      <= RESP_OKAY;
            rstate_q     <= R_IDLE;
            rid_q        <= '0;
            raddr_q      <= '0;
            rlen_q       <= '0;
            rburst_q     <= '0;
            rbeat_q      <= '0;
        end else begin
            calib_cnt_q  <= calib_cnt_d;
            calib_done_q <= calib_done_d;
            wstate_q     <= wstate_d;
            wid_q        <= wid_d;
            waddr_q      <= waddr_d;
            wlen_q       <= wlen_d;
            wburst_q     <= wburst_d;
            wbeat_q      <= wbeat_d;
            werr_q       <= werr_d;
            bresp_q      <= bresp_d;
            rstate_q     <= rstate_d;
            rid_q        <= rid_d;
            raddr_q      <= raddr_d;
            rlen_q       <= rlen_d;
            rburst_q     <= rburst_d;
            rbeat_q      <= rbeat_d;
        end
    end

    axi_ram_mem #(
        .DATA_WIDTH (APP_DATA_WIDTH),
        .ADDR_WIDTH (MEM_WORDS_LOG2)
    ) u_mem (
        .clk     (ui_clk),
        .rst     (ui_rst),
        .wr_en   (mem_we),
        .wr_addr (waddr_q),
        .wr_data (s_axi_wdata),
        .wr_be   (s_axi_wstrb),
        .rd_en   (mem_re),
        .rd_addr (raddr_q),
        .rd_data (s_axi_rdata)
    );

    assign init_calib_complete = calib_done_q;
    assign s_axi_awready       = calib_done_q && (wstate_q == W_IDLE);
    assign s_axi_wready        = (wstate_q == W_DATA);
    assign s_axi_bvalid        = (wstate_q == W_RESP);
    assign s_axi_bid           = wid_q;
    assign s_axi_bresp         = bresp_q;
    assign s_axi_arready       = calib_done_q && (rstate_q == R_IDLE);
    assign s_axi_rvalid        = (rstate_q == R_DATA);
    assign s_axi_rid           = rid_q;
    assign s_axi_rresp         = RESP_OKAY;
    assign s_axi_rlast         = (rstate_q == R_DATA) && (rbeat_q == rlen_q);

    // Sideband fields, transfer size and upper address bits have no effect.
    logic unused;
    assign unused = ^{s_axi_awaddr, s_axi_araddr, s_axi_awsize, s_axi_arsize,
                      s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos,
                      s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos};

endmodule

// File: tb/tb_axi_ram_responder.sv
// Directed testbench for axi_ram_responder: calibration, single/partial writes,
// INCR/FIXED bursts, error response, read-before-write and mid-burst reset.
module tb_axi_ram_responder;

    logic         ui_clk;
    logic         ui_rst;
    logic         init_calib_complete;
    logic [3:0]   s_axi_awid;
    logic [27:0]  s_axi_awaddr;
    logic [7:0]   s_axi_awlen;
    logic [2:0]   s_axi_awsize;
    logic [1:0]   s_axi_awburst;
    logic         s_axi_awvalid;
    logic         s_axi_awready;
    logic [127:0] s_axi_wdata;
    logic [15:0]  s_axi_wstrb;
    logic         s_axi_wlast;
    logic         s_axi_wvalid;
    logic         s_axi_wready;
    logic [3:0]   s_axi_bid;
    logic [1:0]   s_axi_bresp;
    logic         s_axi_bvalid;
    logic         s_axi_bready;
    logic [3:0]   s_axi_arid;
    logic [27:0]  s_axi_araddr;
    logic [7:0]   s_axi_arlen;
    logic [2:0]   s_axi_arsize;
    logic [1:0]   s_axi_arburst;
    logic         s_axi_arvalid;
    logic         s_axi_arready;
    logic [3:0]   s_axi_rid;
    logic [127:0] s_axi_rdata;
    logic [1:0]   s_axi_rresp;
    logic         s_axi_rlast;
    logic         s_axi_rvalid;
    logic         s_axi_rready;

    int n_cmp = 0;
    int n_err = 0;

    axi_ram_responder #(
        .APP_ADDR_WIDTH (28),
        .APP_DATA_WIDTH (128),
        .APP_MASK_WIDTH (16),
        .MEM_WORDS_LOG2 (12),
        .CALIB_CYCLES   (16)
    ) dut (
        .ui_clk              (ui_clk),
        .ui_rst              (ui_rst),
        .init_calib_complete (init_calib_complete),
        .s_axi_awid          (s_axi_awid),
        .s_axi_awaddr        (s_axi_awaddr),
        .s_axi_awlen         (s_axi_awlen),
        .s_axi_awsize        (s_axi_awsize),
        .s_axi_awburst       (s_axi_awburst),
        .s_axi_awlock        (1'b0),
        .s_axi_awcache       (4'b0011),
        .s_axi_awprot        (3'b000),
        .s_axi_awqos         (4'b0000),
        .s_axi_awvalid       (s_axi_awvalid),
        .s_axi_awready       (s_axi_awready),
        .s_axi_wdata         (s_axi_wdata),
        .s_axi_wstrb         (s_axi_wstrb),
        .s_axi_wlast         (s_axi_wlast),
        .s_axi_wvalid        (s_axi_wvalid),
        .s_axi_wready        (s_axi_wready),
        .s_axi_bid           (s_axi_bid),
        .s_axi_bresp         (s_axi_bresp),
        .s_axi_bvalid        (s_axi_bvalid),
        .s_axi_bready        (s_axi_bready),
        .s_axi_arid          (s_axi_arid),
        .s_axi_araddr        (s_axi_araddr),
        .s_axi_arlen         (s_axi_arlen),
        .s_axi_arsize        (s_axi_arsize),
        .s_axi_arburst       (s_axi_arburst),
        .s_axi_arlock        (1'b0),
        .s_axi_arcache       (4'b0011),
        .s_axi_arprot        (3'b000),
        .s_axi_arqos         (4'b0000),
        .s_axi_arvalid       (s_axi_arvalid),
        .s_axi_arready       (s_axi_arready),
        .s_axi_rid           (s_axi_rid),
        .s_axi_rdata         (s_axi_rdata),
        .s_axi_rresp         (s_axi_rresp),
        .s_axi_rlast         (s_axi_rlast),
        .s_axi_rvalid        (s_axi_rvalid),
        .s_axi_rready        (s_axi_rready)
    );

    initial ui_clk = 1'b0;
    always #5 ui_clk = ~ui_clk;

    // Handshake helpers drive at the falling edge and sample there, away from the rising edge.
    task automatic aw_send(input logic [3:0] id, input logic [27:0] addr,
                           input logic [7:0] len, input logic [1:0] burst);
        int n = 0;
        s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len;
        s_axi_awburst = burst; s_axi_awsize = 3'd4; s_axi_awvalid = 1'b1;
        while (!s_axi_awready && n < 200) begin @(negedge ui_clk); n++; end
        n_cmp++;
        if (n >= 200) begin n_err++; $display("FAIL aw_timeout: awready never seen, required 1"); end
        @(negedge ui_clk);
        s_axi_awvalid = 1'b0;
    endtask

    task automatic w_send(input logic [127:0] data, input logic [15:0] strb, input logic last);
        int n = 0;
        s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wlast = last; s_axi_wvalid = 1'b1;
        while (!s_axi_wready && n < 200) begin @(negedge ui_clk); n++; end
        n_cmp++;
        if (n >= 200) begin n_err++; $display("FAIL w_timeout: wready never seen, required 1"); end
        @(negedge ui_clk);
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    endtask

    task automatic b_recv(output logic [3:0] id, output logic [1:0] resp);
        int n = 0;
        s_axi_bready = 1'b1;
        while (!s_axi_bvalid && n < 200) begin @(negedge ui_clk); n++; end
        n_cmp++;
        if (n >= 200) begin n_err++; $display("FAIL b_timeout: bvalid never seen, required 1"); end
        id = s_axi_bid; resp = s_axi_bresp;
        @(negedge ui_clk);
        s_axi_bready = 1'b0;
    endtask

    task automatic ar_send(input logic [3:0] id, input logic [27:0] addr,
                           input logic [7:0] len, input logic [1:0] burst);
        int n = 0;
        s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len;
        s_axi_arburst = burst; s_axi_arsize = 3'd4; s_axi_arvalid = 1'b1;
        while (!s_axi_arready && n < 200) begin @(negedge ui_clk); n++; end
        n_cmp++;
        if (n >= 200) begin n_err++; $display("FAIL ar_timeout: arready never seen, required 1"); end
        @(negedge ui_clk);
        s_axi_arvalid = 1'b0;
    endtask

    task automatic r_recv(output logic [127:0] data, output logic [3:0] id, output logic last);
        int n = 0;
        s_axi_rready = 1'b1;
        while (!s_axi_rvalid && n < 200) begin @(negedge ui_clk); n++; end
        n_cmp++;
        if (n >= 200) begin n_err++; $display("FAIL r_timeout: rvalid never seen, required 1"); end
        data = s_axi_rdata; id = s_axi_rid; last = s_axi_rlast;
        @(negedge ui_clk);
        s_axi_rready = 1'b0;
    endtask

    task automatic test_reset;
        int cyc = 0;
        int early_ready = 0;
        ui_rst = 1'b1;
        repeat (3) @(negedge ui_clk);
        n_cmp++;
        if ({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid,
             s_axi_rlast, init_calib_complete} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b required 0000000", {s_axi_awready, s_axi_wready,
                     s_axi_bvalid, s_axi_arready, s_axi_rvalid, s_axi_rlast, init_calib_complete});
        end
        n_cmp++;
        if ({s_axi_bid, s_axi_bresp, s_axi_rid, s_axi_rresp} !== 12'h0) begin
            n_err++;
            $display("FAIL reset_ids: got %h required 000", {s_axi_bid, s_axi_bresp, s_axi_rid, s_axi_rresp});
        end
        n_cmp++;
        if (s_axi_rdata !== 128'h0) begin
            n_err++; $display("FAIL reset_rdata: got %h required 0", s_axi_rdata);
        end
        // Address valids held high to confirm nothing is accepted before calibration.
        s_axi_awvalid = 1'b1; s_axi_arvalid = 1'b1;
        s_axi_awaddr = 28'h0; s_axi_araddr = 28'h0; s_axi_awlen = 8'd0; s_axi_arlen = 8'd0;
        ui_rst = 1'b0;
        while (cyc < 40) begin
            @(posedge ui_clk); #1;
            cyc++;
            if (init_calib_complete) break;
            if (s_axi_awready || s_axi_arready) early_ready++;
        end
        n_cmp++;
        if (cyc !== 16) begin n_err++; $display("FAIL calib_delay: got %0d cycles required 16", cyc); end
        n_cmp++;
        if (early_ready !== 0) begin n_err++; $display("FAIL calib_ready_gate: got %0d early readies required 0", early_ready); end
        // Drop the valids before the responder can latch either handshake.
        s_axi_awvalid = 1'b0; s_axi_arvalid = 1'b0;
        @(negedge ui_clk);
        n_cmp++;
        if ({s_axi_awready, s_axi_arready} !== 2'b11) begin
            n_err++; $display("FAIL calib_ready: got %b required 11", {s_axi_awready, s_axi_arready});
        end
    endtask

    task automatic test_single_write;
        logic [3:0] id; logic [1:0] resp; logic [127:0] d; logic last;
        aw_send(4'h5, 28'h20, 8'd0, 2'b01);
        w_send(128'h0123456789ABCDEF_FEDCBA9876543210, 16'hFFFF, 1'b1);
        b_recv(id, resp);
        n_cmp++;
        if ({id, resp} !== {4'h5, 2'b00}) begin n_err++; $display("FAIL single_b: got id %h resp %b required id 5 resp 00", id, resp); end
        ar_send(4'h6, 28'h20, 8'd0, 2'b01);
        r_recv(d, id, last);
        n_cmp++;
        if (d !== 128'h0123456789ABCDEF_FEDCBA9876543210) begin n_err++; $display("FAIL single_rdata: got %h required 0123456789abcdeffedcba9876543210", d); end
        n_cmp++;
        if ({id, last} !== {4'h6, 1'b1}) begin n_err++; $display("FAIL single_rid_rlast: got id %h last %b required id 6 last 1", id, last); end
    endtask

    task automatic test_partial_strobe;
        logic [3:0] id; logic [1:0] resp; logic [127:0] d; logic last;
        aw_send(4'h1, 28'h40, 8'd0, 2'b01);
        w_send({128{1'b1}}, 16'hFFFF, 1'b1);
        b_recv(id, resp);
        aw_send(4'h1, 28'h40, 8'd0, 2'b01);
        w_send(128'h0, 16'h00F0, 1'b1);
        b_recv(id, resp);
        ar_send(4'h2, 28'h40, 8'd0, 2'b01);
        r_recv(d, id, last);
        n_cmp++;
        if (d !== {64'hFFFFFFFF_FFFFFFFF, 32'h0, 32'hFFFFFFFF}) begin
            n_err++; $display("FAIL partial_strobe: got %h required ffffffffffffffff00000000ffffffff", d);
        end
    endtask

    task automatic test_incr_burst;
        logic [3:0] id; logic [1:0] resp; logic [127:0] first;
        aw_send(4'h3, 28'h100, 8'd3, 2'b01);
        for (int b = 0; b < 4; b++) w_send(128'(b + 1), 16'hFFFF, b == 3);
        b_recv(id, resp);
        n_cmp++;
        if ({id, resp} !== {4'h3, 2'b00}) begin n_err++; $display("FAIL incr_b: got id %h resp %b required id 3 resp 00", id, resp); end
        ar_send(4'h4, 28'h100, 8'd3, 2'b01);
        s_axi_rready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            int n = 0;
            while (!s_axi_rvalid && n < 200) begin @(negedge ui_clk); n++; end
            n_cmp++;
            if (n >= 200) begin n_err++; $display("FAIL incr_r_timeout: beat %0d rvalid never seen", b); end
            first = s_axi_rdata;
            n_cmp++;
            if (s_axi_rdata !== 128'(b + 1)) begin n_err++; $display("FAIL incr_rdata: beat %0d got %h required %0d", b, s_axi_rdata, b + 1); end
            n_cmp++;
            if ({s_axi_rlast, s_axi_rid} !== {(b == 3), 4'h4}) begin n_err++; $display("FAIL incr_rlast_rid: beat %0d got last %b id %h required last %b id 4", b, s_axi_rlast, s_axi_rid, b == 3); end
            @(negedge ui_clk);
            n_cmp++;
            if ({s_axi_rvalid, s_axi_rdata} !== {1'b1, first}) begin n_err++; $display("FAIL incr_stall_hold: beat %0d got valid %b data %h required valid 1 data %h", b, s_axi_rvalid, s_axi_rdata, first); end
            s_axi_rready = 1'b1;
            @(negedge ui_clk);
            s_axi_rready = 1'b0;
        end
        n_cmp++;
        if (s_axi_rvalid !== 1'b0) begin n_err++; $display("FAIL incr_end: rvalid got %b required 0", s_axi_rvalid); end
    endtask

    task automatic test_fixed_and_error;
        logic [3:0] id; logic [1:0] resp; logic [127:0] d; logic last;
        aw_send(4'h7, 28'h200, 8'd1, 2'b00);
        w_send(128'hAAAA, 16'hFFFF, 1'b0);
        w_send(128'hBBBB, 16'hFFFF, 1'b1);
        b_recv(id, resp);
        n_cmp++;
        if (resp !== 2'b00) begin n_err++; $display("FAIL fixed_bresp: got %b required 00", resp); end
        ar_send(4'h7, 28'h200, 8'd0, 2'b01);
        r_recv(d, id, last);
        n_cmp++;
        if (d !== 128'hBBBB) begin n_err++; $display("FAIL fixed_rdata: got %h required bbbb", d); end
        aw_send(4'h8, 28'h300, 8'd2, 2'b01);
        w_send(128'h1, 16'hFFFF, 1'b1);
        w_send(128'h2, 16'hFFFF, 1'b0);
        w_send(128'h3, 16'hFFFF, 1'b1);
        b_recv(id, resp);
        n_cmp++;
        if ({id, resp} !== {4'h8, 2'b10}) begin n_err++; $display("FAIL early_wlast_bresp: got id %h resp %b required id 8 resp 10", id, resp); end
    endtask

    task automatic test_concurrent_rbw;
        logic [3:0] id; logic [1:0] resp; logic [127:0] d; logic last;
        aw_send(4'h9, 28'h400, 8'd0, 2'b01);
        w_send(128'hDEAD_0001, 16'hFFFF, 1'b1);
        b_recv(id, resp);
        // AW and AR accepted on one edge, then W beat and read fetch collide on the next.
        s_axi_awid = 4'hA; s_axi_awaddr = 28'h400; s_axi_awlen = 8'd0; s_axi_awburst = 2'b01; s_axi_awvalid = 1'b1;
        s_axi_arid = 4'hB; s_axi_araddr = 28'h400; s_axi_arlen = 8'd0; s_axi_arburst = 2'b01; s_axi_arvalid = 1'b1;
        s_axi_wdata = 128'hBEEF_0002; s_axi_wstrb = 16'hFFFF; s_axi_wlast = 1'b1; s_axi_wvalid = 1'b1;
        n_cmp++;
        if ({s_axi_awready, s_axi_arready} !== 2'b11) begin n_err++; $display("FAIL conc_ready: got %b required 11", {s_axi_awready, s_axi_arready}); end
        @(negedge ui_clk);
        s_axi_awvalid = 1'b0; s_axi_arvalid = 1'b0;
        n_cmp++;
        if (s_axi_wready !== 1'b1) begin n_err++; $display("FAIL conc_wready: got %b required 1", s_axi_wready); end
        @(negedge ui_clk);
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
        r_recv(d, id, last);
        n_cmp++;
        if (d !== 128'hDEAD_0001) begin n_err++; $display("FAIL conc_old_data: got %h required dead0001", d); end
        b_recv(id, resp);
        n_cmp++;
        if ({id, resp} !== {4'hA, 2'b00}) begin n_err++; $display("FAIL conc_b: got id %h resp %b required id a resp 00", id, resp); end
        ar_send(4'hC, 28'h400, 8'd0, 2'b01);
        r_recv(d, id, last);
        n_cmp++;
        if (d !== 128'hBEEF_0002) begin n_err++; $display("FAIL conc_new_data: got %h required beef0002", d); end
    endtask

    task automatic test_reset_mid_burst;
        logic [3:0] id; logic [127:0] d; logic last;
        int n = 0;
        int seen = 0;
        ar_send(4'hD, 28'h100, 8'd3, 2'b01);
        r_recv(d, id, last);
        n_cmp++;
        if (d !== 128'h1) begin n_err++; $display("FAIL midrst_beat0: got %h required 1", d); end
        while (!s_axi_rvalid && n < 200) begin @(negedge ui_clk); n++; end
        ui_rst = 1'b1;
        #1;
        n_cmp++;
        if ({s_axi_rvalid, s_axi_rlast, s_axi_arready, init_calib_complete} !== 4'b0) begin
            n_err++; $display("FAIL midrst_drop: got %b required 0000", {s_axi_rvalid, s_axi_rlast, s_axi_arready, init_calib_complete});
        end
        @(negedge ui_clk);
        ui_rst = 1'b0;
        s_axi_rready = 1'b1; s_axi_bready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge ui_clk);
            if (s_axi_rvalid || s_axi_bvalid) seen++;
        end
        s_axi_rready = 1'b0; s_axi_bready = 1'b0;
        n_cmp++;
        if (seen !== 0) begin n_err++; $display("FAIL midrst_no_resp: got %0d response cycles required 0", seen); end
        ar_send(4'hE, 28'h100, 8'd0, 2'b01);
        r_recv(d, id, last);
        n_cmp++;
        if (d !== 128'h1) begin n_err++; $display("FAIL midrst_ram_kept: got %h required 1", d); end
    endtask

    initial begin
        ui_rst = 1'b1;
        s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0; s_axi_awburst = '0;
        s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b0; s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0;
        s_axi_arburst = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
        test_reset;
        test_single_write;
        test_partial_strobe;
        test_incr_burst;
        test_fixed_and_error;
        test_concurrent_rbw;
        test_reset_mid_burst;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axi_ram_responder.md
Name: axi_ram_responder

Overview:
- AXI4 slave (responder) with an internal RAM array.
- Stands in for the MIG DDR AXI port in simulation and small FPGA builds, so our DRAM AXI initiator can run against it unchanged.
- Supports single-beat and burst (FIXED/INCR) reads and writes, with one outstanding transaction per direction.
- Read and write channels run concurrently. A calibration-done output mimics MIG start-up.

Parameters:
- APP_ADDR_WIDTH, 28, byte address width on AXI.
- APP_DATA_WIDTH, 128, data bus width.
- APP_MASK_WIDTH, 16, strobe width (APP_DATA_WIDTH/8).
- MEM_WORDS_LOG2, 12, log2 of RAM depth in data words.
- CALIB_CYCLES, 16, cycles after reset before init_calib_complete rises (minimum 1).

Ports:
- ui_clk  in  1  clock
- ui_rst  in  1  asynchronous reset, active-high
- init_calib_complete  out  1  high once calibration delay has elapsed
- s_axi_awid/awaddr/awlen/awsize/awburst  in  4/APP_ADDR_WIDTH/8/3/2  write address; awlock/awcache/awprot/awqos are inputs and are ignored
- s_axi_awvalid in 1; s_axi_awready out 1
- s_axi_wdata/wstrb/wlast/wvalid  in  APP_DATA_WIDTH/APP_MASK_WIDTH/1/1; s_axi_wready out 1
- s_axi_bid/bresp/bvalid  out  4/2/1; s_axi_bready in 1
- s_axi_arid/araddr/arlen/arsize/arburst  in  4/APP_ADDR_WIDTH/8/3/2; arlock/arcache/arprot/arqos are inputs and are ignored
- s_axi_arvalid in 1; s_axi_arready out 1
- s_axi_rid/rdata/rresp/rlast/rvalid  out  4/APP_DATA_WIDTH/2/1/1; s_axi_rready in 1

Behaviour:
- Reset (async, while ui_rst=1):
  - All outputs are 0: readies, valids, bid, bresp, rid, rdata, rresp, rlast, init_calib_complete.
  - Both FSMs go to IDLE and the calibration counter clears.
  - RAM contents are preserved.
  - A reset mid-burst abandons the transaction; no response is issued.
- Calibration:
  - Counter increments from reset release.
  - init_calib_complete goes high after CALIB_CYCLES cycles and stays high.
  - awready and arready stay 0 until then.
- Addressing:
  - Word index = addr[4 +: MEM_WORDS_LOG2] (LSB = log2(APP_MASK_WIDTH)).
  - Upper bits are ignored, so the array aliases.
  - awsize/arsize are ignored; every beat is full width.
  - INCR adds 1 word per beat and wraps modulo the depth. FIXED holds the address. WRAP (2'b10) is treated as INCR.
- Write FSM, W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: awready=1. On awvalid&awready, capture id, word index, len and burst; go to W_DATA.
  - W_DATA: wready=1. Each wvalid beat writes the RAM byte lanes whose wstrb bit is 1, then advances the beat counter.
  - The burst ends at beat awlen+1, regardless of wlast.
  - bresp is OKAY (2'b00). It is SLVERR (2'b10) if wlast was 1 on any earlier beat or 0 on the final beat.
  - W_RESP: bvalid=1 with bid = captured id. Stay until bready, then return to W_IDLE. Minimum AW-to-B latency is 2 cycles for len=0.
- Read FSM, R_IDLE -> R_FETCH -> R_DATA:
  - R_IDLE: arready=1. On handshake, capture id, word index, len, burst; go to R_FETCH.
  - R_FETCH: the RAM read is issued and its output is registered into rdata next cycle. Go to R_DATA.
  - R_DATA: rvalid=1, rid = captured id, rresp=OKAY, rlast=1 on beat arlen.
  - rdata, rid and rlast are held stable while rvalid & !rready.
  - On rready: if last, go to R_IDLE with rvalid=0; else advance the address and go to R_FETCH. This gives one bubble cycle between beats.
- Simultaneous events:
  - If a write and a read fetch hit the same word in the same cycle, the read returns old data (read-before-write).
  - AR and AW handshakes in the same cycle are both accepted.
  - A new AW/AR is not accepted until the previous transaction in that direction completes.

Decomposition:
- Package axi_ram_pkg holds:
  - RESP_OKAY/RESP_SLVERR
  - BURST_FIXED/INCR/WRAP
  - write and read state encodings
  - the ADDR_LSB function
- Sub-module axi_ram_mem: simple dual-port RAM with one write port (byte enables) and one read port with a registered read, parameterized by width and depth.

Test Plan:
- Release reset with CALIB_CYCLES=16 -> init_calib_complete rises exactly 16 cycles later; awready/arready are 0 before that.
- Single write: addr 0x20, data 0x0123..EF, wstrb 16'hFFFF, then read 0x20 -> bresp=00, bid matches, rdata=written value, rlast=1.
- Partial strobe: write 0xFF..FF, then write 0x00..00 with wstrb=16'h00F0, then read -> bytes 4-7 are 0x00, all others 0xFF.
- INCR burst: awlen=3 at 0x100 with data 1..4, then read arlen=3 at 0x100 with rready toggling 1/0 -> beats 1,2,3,4 in order, values stable under stall, rlast only on beat 4.
- FIXED burst: awlen=1 with data A then B, then single read -> returns B. Early wlast on beat 1 of awlen=2 -> bresp=2'b10.
- Concurrent AW and AR to the same word in the same cycle with old value X, new value Y -> read returns X, a later read returns Y. Assert ui_rst mid-read-burst -> rvalid drops immediately and no B or R is seen afterwards.
